alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational integer ALU between two requesters:
- port 0: the core execute pipeline;
- port 1: the quantum pulse/measurement sequencer, for address and phase arithmetic.

Each requester uses a valid/ready request channel and a one-entry registered response channel with a tag. Arbitration is round-robin, or fixed priority to port 0 by parameter. The block sits beside the execute stage and instantiates the existing 4-bit-opcode ALU once.

Parameters:
- TAG_W, 4, width of the requester tag echoed back with the result.
- RR_EN, 1, 1 = round-robin between ports; 0 = port 0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid_0 / req_valid_1  in  1  request present.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle.
- req_op_0 / req_op_1  in  4  ALU opcode.
- req_a_0 / req_a_1  in  32  operand A.
- req_b_0 / req_b_1  in  32  operand B.
- req_tag_0 / req_tag_1  in  TAG_W  requester tag.
- rsp_valid_0 / rsp_valid_1  out  1  response held.
- rsp_ready_0 / rsp_ready_1  in  1  requester consumes response.
- rsp_result_0 / rsp_result_1  out  32  ALU result.
- rsp_tag_0 / rsp_tag_1  out  TAG_W  echoed tag.
- rsp_err_0 / rsp_err_1  out  1  opcode was illegal (4'hA..4'hF).

Behaviour:
- Reset (rst_n low, async):
  - rsp_valid_x, rsp_result_x, rsp_tag_x, rsp_err_x = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - req_ready_x = 0 while in reset.
- Slot and eligibility:
  - slot_free_x = !rsp_valid_x || rsp_ready_x. A response drained this cycle frees the slot this cycle.
  - eligible_x = req_valid_x && slot_free_x.
- Arbitration (combinational, at most one grant per cycle):
  - Only one port eligible -> that port wins.
  - Both eligible, RR_EN=1 -> grant the port != last_grant.
  - Both eligible, RR_EN=0 -> grant port 0.
- Ready: req_ready_x = grant_x. Ready depends combinationally on valid; requesters must not make valid depend on ready.
- Transfer: req_valid_x && req_ready_x.
  - The granted port's op/a/b drive the shared ALU.
  - At the next rising edge:
    - rsp_result_x <= ALU result.
    - rsp_tag_x <= req_tag_x.
    - rsp_err_x <= (op > 4'h9).
    - rsp_valid_x <= 1.
    - last_grant <= x.
  - Latency: accept in cycle N -> rsp_valid in cycle N+1.
  - Throughput: 1 op/cycle total. Back-to-back on one port is allowed if rsp_ready is held high.
- Response hold:
  - While rsp_valid_x && !rsp_ready_x, result/tag/err are stable and the port receives no grant.
  - If rsp_ready_x is high and there is no new transfer, rsp_valid_x <= 0 next edge. The data registers hold their last value (don't-care).
  - Drain and a new transfer in the same cycle -> rsp_valid_x stays 1 with the new data.
- Illegal opcode: the ALU still evaluates (result 0) and rsp_err=1. This is not a fatal condition; arbitration is unaffected.
- No-grant cycle: last_grant is unchanged; the ALU operands are driven from port 0 (don't-care).
- Ports are independent: a stalled response on one port never blocks the other port.
- Reset mid-operation: held responses are discarded and no response is issued for an in-flight accept.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - ALU_OP_LAST = 4'h9.
  - ALU_W = 32.
- Sub-module rr_arb2:
  - 2-way round-robin / fixed-priority arbiter with the last_grant flop.
  - Inputs: eligible[1:0], rr_en, advance.
  - Output: one-hot grant[1:0].
- The top module holds the response slots and the single ALU instance.

Test Plan:
- Single op: port 0 requests ADD a=5 b=7 tag=3, rsp_ready_0=1 -> next cycle rsp_valid_0=1, result=12, tag=3, err=0; port 1 silent.
- Contention round-robin, RR_EN=1, both ports valid every cycle, all rsp_ready=1:
  - port 0 SUB 10-3 at cycle 0 -> 7 at cycle 1.
  - port 1 SRA 0x80000000>>>4 at cycle 1 -> 0xF8000000 at cycle 2.
  - grants strictly alternate 0,1,0,1.
- Backpressure: port 1 rsp_ready_1=0 after one SLTU (a=1, b=0xFFFFFFFF -> 1):
  - port 1 result holds 1 and req_ready_1 stays 0 for 5 cycles;
  - port 0 is granted every cycle meanwhile;
  - raising rsp_ready_1 with a pending SLT (a=-1, b=0) gives same-cycle accept and result 1 next cycle.
- Fixed priority, RR_EN=0, both valid for 4 cycles -> port 0 is granted all 4; port 1 is granted on the first cycle port 0 drops valid.
- Illegal op: port 0 op=4'hC a=1 b=1 -> result 0, rsp_err_0=1; a following ADD 1+1 -> result 2, err=0.
- Reset: assert rst_n low while rsp_valid_0=1 and a port 1 request is being accepted -> all rsp_valid=0 immediately; after release, the first tie is granted to port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and opcode legality.
// Pure definitions, no logic; imported by the ALU, the arbiter and its interface.
package alu_pkg;
    localparam int         ALU_W       = 32;
    localparam int         SHAMT_W     = 5;
    localparam logic [3:0] ALU_OP_LAST = 4'h9;

    typedef enum logic [3:0] {
        ADD  = 4'h0,
        SUB  = 4'h1,
        AND  = 4'h2,
        OR   = 4'h3,
        XOR  = 4'h4,
        SLL  = 4'h5,
        SRL  = 4'h6,
        SRA  = 4'h7,
        SLT  = 4'h8,
        SLTU = 4'h9
    } alu_op_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > ALU_OP_LAST;
    endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's request channel (valid/ready) and held response channel.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int TAG_W = 4
);
    import alu_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_op;
    logic [ALU_W-1:0]     req_a;
    logic [ALU_W-1:0]     req_b;
    logic [TAG_W-1:0]     req_tag;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ALU_W-1:0]     rsp_result;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Combinational 4-bit-opcode integer ALU. Latency: 0 cycles; no flow control.
// Opcodes above SLTU produce a zero result.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] result
);
    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        result = '0;
        case (op)
            ADD:     result = a + b;
            SUB:     result = a - b;
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            SLL:     result = a << shamt;
            SRL:     result = a >> shamt;
            SRA:     result = $signed(a) >>> shamt;
            SLT:     result = {{(ALU_W-1){1'b0}}, $signed(a) < $signed(b)};
            SLTU:    result = {{(ALU_W-1){1'b0}}, a < b};
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter, round-robin or fixed priority to port 0. Latency: 0 cycles (grant is
// combinational); the last-grant pointer moves only on cycles that actually grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    input  logic       rr_en,
    input  logic       advance,
    output logic [1:0] grant
);
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr_en && !last_grant_q) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance) begin
            last_grant_d = grant[1];
        end
    end

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters with one-entry registered response slots.
// Latency: accept in N -> response in N+1. A port whose held response is not drained gets no grant.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave p0,
    alu_share_arbiter_if.slave p1
);
    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    logic [1:0]       req_vld;
    logic [1:0]       rsp_rdy;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [3:0]       req_op  [2];
    logic [ALU_W-1:0] req_a   [2];
    logic [ALU_W-1:0] req_b   [2];
    logic [TAG_W-1:0] req_tag [2];
    logic [1:0]       rsp_vld_q;
    logic [1:0]       rsp_vld_d;
    rsp_t             rsp_q [2];
    rsp_t             rsp_d [2];
    logic [3:0]       alu_op;
    logic [ALU_W-1:0] alu_a;
    logic [ALU_W-1:0] alu_b;
    logic [ALU_W-1:0] alu_res;

    assign req_vld    = {p1.req_valid, p0.req_valid};
    assign rsp_rdy    = {p1.rsp_ready, p0.rsp_ready};
    assign req_op[0]  = p0.req_op;
    assign req_op[1]  = p1.req_op;
    assign req_a[0]   = p0.req_a;
    assign req_a[1]   = p1.req_a;
    assign req_b[0]   = p0.req_b;
    assign req_b[1]   = p1.req_b;
    assign req_tag[0] = p0.req_tag;
    assign req_tag[1] = p1.req_tag;

    // A slot drained this cycle may be refilled this cycle; nothing is granted in reset.
    assign eligible = {2{rst_n}} & req_vld & (~rsp_vld_q | rsp_rdy);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .rr_en    (RR_EN),
        .advance  (|grant),
        .grant    (grant)
    );

    assign alu_op = grant[1] ? req_op[1] : req_op[0];
    assign alu_a  = grant[1] ? req_a[1]  : req_a[0];
    assign alu_b  = grant[1] ? req_b[1]  : req_b[0];

    alu u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res)
    );

    always_comb begin
        rsp_vld_d = rsp_vld_q & ~rsp_rdy;
        rsp_d     = rsp_q;
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                rsp_vld_d[i]    = 1'b1;
                rsp_d[i].result = alu_res;
                rsp_d[i].tag    = req_tag[i];
                rsp_d[i].err    = op_illegal(alu_op);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= '0;
            rsp_q[0]  <= '0;
            rsp_q[1]  <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_q[0]  <= rsp_d[0];
            rsp_q[1]  <= rsp_d[1];
        end
    end

    assign p0.req_ready  = grant[0];
    assign p1.req_ready  = grant[1];
    assign p0.rsp_valid  = rsp_vld_q[0];
    assign p1.rsp_valid  = rsp_vld_q[1];
    assign p0.rsp_result = rsp_q[0].result;
    assign p1.rsp_result = rsp_q[1].result;
    assign p0.rsp_tag    = rsp_q[0].tag;
    assign p1.rsp_tag    = rsp_q[1].tag;
    assign p0.rsp_err    = rsp_q[0].err;
    assign p1.rsp_err    = rsp_q[1].err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and checks
// both against a cycle-level behavioural model, plus directed literal expectations.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  in_vld;
    logic [1:0]  in_rrdy;
    logic [3:0]  in_op  [2];
    logic [31:0] in_a   [2];
    logic [31:0] in_b   [2];
    logic [3:0]  in_tag [2];

    // Index k = 2*instance + port; instance 0 is round-robin, instance 1 fixed priority.
    logic        o_rdy [4];
    logic        o_rv  [4];
    logic        o_err [4];
    logic [31:0] o_res [4];
    logic [3:0]  o_tag [4];

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_last [2];
    bit          m_rv   [4];
    logic [31:0] m_res  [4];
    logic [3:0]  m_tag  [4];
    bit          m_err  [4];

    alu_share_arbiter_if #(.TAG_W(4)) if_r0 ();
    alu_share_arbiter_if #(.TAG_W(4)) if_r1 ();
    alu_share_arbiter_if #(.TAG_W(4)) if_f0 ();
    alu_share_arbiter_if #(.TAG_W(4)) if_f1 ();

    alu_share_arbiter #(.TAG_W(4), .RR_EN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .p0(if_r0), .p1(if_r1));
    alu_share_arbiter #(.TAG_W(4), .RR_EN(1'b0)) u_fx (.clk(clk), .rst_n(rst_n), .p0(if_f0), .p1(if_f1));

    assign if_r0.req_valid = in_vld[0];  assign if_r0.req_op = in_op[0];  assign if_r0.req_a = in_a[0];
    assign if_r0.req_b = in_b[0];  assign if_r0.req_tag = in_tag[0];  assign if_r0.rsp_ready = in_rrdy[0];
    assign if_r1.req_valid = in_vld[1];  assign if_r1.req_op = in_op[1];  assign if_r1.req_a = in_a[1];
    assign if_r1.req_b = in_b[1];  assign if_r1.req_tag = in_tag[1];  assign if_r1.rsp_ready = in_rrdy[1];
    assign if_f0.req_valid = in_vld[0];  assign if_f0.req_op = in_op[0];  assign if_f0.req_a = in_a[0];
    assign if_f0.req_b = in_b[0];  assign if_f0.req_tag = in_tag[0];  assign if_f0.rsp_ready = in_rrdy[0];
    assign if_f1.req_valid = in_vld[1];  assign if_f1.req_op = in_op[1];  assign if_f1.req_a = in_a[1];
    assign if_f1.req_b = in_b[1];  assign if_f1.req_tag = in_tag[1];  assign if_f1.rsp_ready = in_rrdy[1];

    assign o_rdy[0] = if_r0.req_ready;  assign o_rv[0] = if_r0.rsp_valid;  assign o_res[0] = if_r0.rsp_result;
    assign o_tag[0] = if_r0.rsp_tag;    assign o_err[0] = if_r0.rsp_err;
    assign o_rdy[1] = if_r1.req_ready;  assign o_rv[1] = if_r1.rsp_valid;  assign o_res[1] = if_r1.rsp_result;
    assign o_tag[1] = if_r1.rsp_tag;    assign o_err[1] = if_r1.rsp_err;
    assign o_rdy[2] = if_f0.req_ready;  assign o_rv[2] = if_f0.rsp_valid;  assign o_res[2] = if_f0.rsp_result;
    assign o_tag[2] = if_f0.rsp_tag;    assign o_err[2] = if_f0.rsp_err;
    assign o_rdy[3] = if_f1.req_ready;  assign o_rv[3] = if_f1.rsp_valid;  assign o_res[3] = if_f1.rsp_result;
    assign o_tag[3] = if_f1.rsp_tag;    assign o_err[3] = if_f1.rsp_err;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        logic [31:0] fill;
        s = int'(b % 32);
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << s;
            4'h6: return a >> s;
            4'h7: return (a >> s) | fill;
            4'h8: return ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Model compare on every falling edge; inputs are stable between rising edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_last[0] = 1'b1;
            m_last[1] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                m_rv[k] = 1'b0; m_res[k] = '0; m_tag[k] = '0; m_err[k] = 1'b0;
                chk($sformatf("reset_rdy_%0d", k), 32'(o_rdy[k]), 32'd0);
                chk($sformatf("reset_rv_%0d", k), 32'(o_rv[k]), 32'd0);
                chk($sformatf("reset_res_%0d", k), o_res[k], 32'd0);
                chk($sformatf("reset_tag_%0d", k), 32'(o_tag[k]), 32'd0);
                chk($sformatf("reset_err_%0d", k), 32'(o_err[k]), 32'd0);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit el [2];
                int g;
                for (int p = 0; p < 2; p++) el[p] = in_vld[p] && (!m_rv[2*i+p] || in_rrdy[p]);
                g = -1;
                if (el[0] && el[1]) g = (i == 0) ? (m_last[i] ? 0 : 1) : 0;
                else if (el[0]) g = 0;
                else if (el[1]) g = 1;
                for (int p = 0; p < 2; p++) begin
                    int k;
                    k = 2*i + p;
                    chk($sformatf("model_rdy_%0d", k), 32'(o_rdy[k]), 32'(g == p));
                    chk($sformatf("model_rv_%0d", k), 32'(o_rv[k]), 32'(m_rv[k]));
                    if (m_rv[k]) begin
                        chk($sformatf("model_res_%0d", k), o_res[k], m_res[k]);
                        chk($sformatf("model_tag_%0d", k), 32'(o_tag[k]), 32'(m_tag[k]));
                        chk($sformatf("model_err_%0d", k), 32'(o_err[k]), 32'(m_err[k]));
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    int k;
                    k = 2*i + p;
                    if (g == p) begin
                        m_rv[k]  = 1'b1;
                        m_res[k] = alu_ref(in_op[p], in_a[p], in_b[p]);
                        m_tag[k] = in_tag[p];
                        m_err[k] = in_op[p] > 4'h9;
                    end else if (in_rrdy[p]) begin
                        m_rv[k] = 1'b0;
                    end
                end
                if (g >= 0) m_last[i] = (g == 1);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int p, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        in_vld[p] = v; in_op[p] = op; in_a[p] = a; in_b[p] = b; in_tag[p] = tag;
    endtask

    initial begin
        in_rrdy = 2'b11;
        req(0, 1'b1, ADD, 0, 0, 0);
        req(1, 1'b1, ADD, 0, 0, 0);
        chk("ref_sra", alu_ref(SRA, 32'h8000_0000, 4), 32'hF800_0000);
        chk("ref_slt", alu_ref(SLT, 32'hFFFF_FFFF, 0), 32'd1);
        chk("ref_sltu", alu_ref(SLTU, 32'd1, 32'hFFFF_FFFF), 32'd1);
        chk("ref_sub", alu_ref(SUB, 32'd3, 32'd5), 32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        chk("reset_ready_gated", 32'(o_rdy[0]), 32'd0);
        nxt();
        rst_n = 1'b1;
        in_vld = 2'b00;

        // Single op on port 0.
        req(0, 1'b1, ADD, 5, 7, 3);
        @(negedge clk); chk("s1_rdy0", 32'(o_rdy[0]), 1);
        nxt(); in_vld = 2'b00;
        @(negedge clk);
        chk("s1_rv0", 32'(o_rv[0]), 1); chk("s1_res0", o_res[0], 12);
        chk("s1_tag0", 32'(o_tag[0]), 3); chk("s1_err0", 32'(o_err[0]), 0);
        chk("s1_rv1", 32'(o_rv[1]), 0);

        // Port 1 alone so the next tie goes to port 0, then strict alternation.
        nxt(); req(1, 1'b1, ADD, 1, 1, 0);
        @(negedge clk);
        nxt();
        req(0, 1'b1, SUB, 10, 3, 1); req(1, 1'b1, SRA, 32'h8000_0000, 4, 2);
        @(negedge clk); chk("rr_c0_rdy0", 32'(o_rdy[0]), 1); chk("rr_c0_rdy1", 32'(o_rdy[1]), 0);
        nxt(); req(0, 1'b1, XOR, 32'hF0, 32'h0F, 4);
        @(negedge clk); chk("rr_c1_rdy0", 32'(o_rdy[0]), 0); chk("rr_c1_rdy1", 32'(o_rdy[1]), 1);
        chk("rr_c1_res0", o_res[0], 7);
        nxt(); req(1, 1'b1, OR, 1, 2, 5);
        @(negedge clk); chk("rr_c2_rdy0", 32'(o_rdy[0]), 1); chk("rr_c2_rdy1", 32'(o_rdy[1]), 0);
        chk("rr_c2_res1", o_res[1], 32'hF800_0000); chk("rr_c2_tag1", 32'(o_tag[1]), 2);
        nxt();
        @(negedge clk); chk("rr_c3_rdy0", 32'(o_rdy[0]), 0); chk("rr_c3_rdy1", 32'(o_rdy[1]), 1);
        chk("rr_c3_res0", o_res[0], 32'hFF);
        nxt(); in_vld = 2'b00;
        @(negedge clk); chk("rr_c4_res1", o_res[1], 3);

        // Backpressure on port 1 while port 0 streams.
        nxt(); req(1, 1'b1, SLTU, 1, 32'hFFFF_FFFF, 5);
        @(negedge clk); chk("bp_acc1", 32'(o_rdy[1]), 1);
        nxt(); in_rrdy[1] = 1'b0; req(1, 1'b1, SLT, 32'hFFFF_FFFF, 0, 6);
        for (int c = 0; c < 5; c++) begin
            req(0, 1'b1, ADD, c, c, 4'(c));
            @(negedge clk);
            chk("bp_rv1", 32'(o_rv[1]), 1); chk("bp_res1", o_res[1], 1);
            chk("bp_rdy1", 32'(o_rdy[1]), 0); chk("bp_rdy0", 32'(o_rdy[0]), 1);
            nxt();
        end
        in_rrdy[1] = 1'b1;
        @(negedge clk); chk("bp_release_rdy1", 32'(o_rdy[1]), 1); chk("bp_release_rdy0", 32'(o_rdy[0]), 0);
        nxt(); in_vld = 2'b00;
        @(negedge clk); chk("bp_slt_res1", o_res[1], 1); chk("bp_slt_tag1", 32'(o_tag[1]), 6);

        // Fixed-priority instance: port 0 wins every tie.
        for (int c = 0; c < 4; c++) begin
            nxt(); req(0, 1'b1, AND, 32'hFF, c, 1); req(1, 1'b1, OR, c, 1, 2);
            @(negedge clk); chk("fx_rdy0", 32'(o_rdy[2]), 1); chk("fx_rdy1", 32'(o_rdy[3]), 0);
        end
        nxt(); in_vld[0] = 1'b0;
        @(negedge clk); chk("fx_p1_after_drop", 32'(o_rdy[3]), 1);
        nxt(); in_vld = 2'b00;

        // Illegal opcode then a legal one.
        req(0, 1'b1, 4'hC, 1, 1, 7);
        @(negedge clk);
        nxt(); req(0, 1'b1, ADD, 1, 1, 8);
        @(negedge clk); chk("ill_res0", o_res[0], 0); chk("ill_err0", 32'(o_err[0]), 1); chk("ill_tag0", 32'(o_tag[0]), 7);
        nxt(); in_vld = 2'b00;
        @(negedge clk); chk("legal_res0", o_res[0], 2); chk("legal_err0", 32'(o_err[0]), 0);

        // Randomised traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            nxt();
            for (int p = 0; p < 2; p++) begin
                req(p, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)), 4'($urandom_range(0, 15)));
                in_rrdy[p] = $urandom_range(0, 3) != 0;
            end
        end

        // Reset while a response is held and a port 1 request is being accepted.
        nxt(); in_vld = 2'b00; in_rrdy = 2'b11;
        @(negedge clk);
        nxt(); in_rrdy[0] = 1'b0; req(0, 1'b1, ADD, 2, 3, 9);
        @(negedge clk);
        nxt(); in_vld[0] = 1'b0; req(1, 1'b1, ADD, 4, 4, 1);
        @(negedge clk); chk("rst_pre_rv0", 32'(o_rv[0]), 1); chk("rst_pre_acc1", 32'(o_rdy[1]), 1);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_async_rv", 32'(o_rv[k]), 0);
            chk("rst_async_rdy", 32'(o_rdy[k]), 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; in_rrdy = 2'b11;
        req(0, 1'b1, ADD, 1, 2, 1); req(1, 1'b1, ADD, 3, 4, 2);
        @(negedge clk);
        chk("rst_tie_rdy0", 32'(o_rdy[0]), 1); chk("rst_tie_rdy1", 32'(o_rdy[1]), 0);
        chk("rst_no_rsp1", 32'(o_rv[1]), 0);
        nxt(); in_vld = 2'b00;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
